// File: rtl/wb_pkg.sv
// Shared status codes and controller state encodings for the Wishbone initiator.
// Status values appear on status_o alongside the done_o pulse.
package wb_pkg;

  localparam logic [1:0] WB_ST_OK  = 2'd0;
  localparam logic [1:0] WB_ST_ERR = 2'd1;
  localparam logic [1:0] WB_ST_TMO = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_REQ   = 3'd2,
    ST_BUS   = 3'd3,
    ST_DONE  = 3'd4
  } wb_state_e;

endpackage

// File: rtl/wb_master_ctl_if.sv
// Command, write/read stream, completion and Wishbone signals of the initiator.
// master = the controller, slave = whatever drives commands/streams and the bus slave.
interface wb_master_ctl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic                    cmd_we;
  logic [SELECT_WIDTH-1:0] cmd_sel;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic                    done_o;
  logic [1:0]              status_o;
  logic [LEN_WIDTH:0]      beats_o;
  logic                    busy_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_we_o;
  logic [SELECT_WIDTH-1:0] wb_sel_o;
  logic                    wb_stb_o;
  logic                    wb_ack_i;
  logic                    wb_err_i;
  logic                    wb_cyc_o;

  modport master (
    input  cmd_addr, cmd_len, cmd_we, cmd_sel, cmd_valid, wr_data, wr_valid, rd_ready,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready, wr_ready, rd_data, rd_valid, done_o, status_o, beats_o, busy_o,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_we, cmd_sel, cmd_valid, wr_data, wr_valid, rd_ready,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done_o, status_o, beats_o, busy_o,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// Strobe-wait watchdog: held at zero by clr, counts while en, flags expiry at TIMEOUT-1.
// TIMEOUT=0 removes the counter entirely and never expires.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk, rst_n, clr, en};
    assign expired    = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (en && !expired)   cnt <= cnt + CW'(1);
    end

    assign expired = en && (cnt == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/wb_master_ctl.sv
// Command-driven Wishbone classic initiator: single/incrementing bursts bridged to valid/ready streams.
// Registered outputs; each beat takes >=2 cycles since stb drops for a cycle after every ack.
module wb_master_ctl
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 8,
  parameter int TIMEOUT      = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_master_ctl_if.master bus
);

  wb_state_e             state;
  logic [LEN_WIDTH-1:0]  rem;
  logic [LEN_WIDTH:0]    beat_cnt;
  logic                  tmo_expired;
  logic                  fin;
  logic [1:0]            fin_st;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!bus.wb_stb_o),
    .en      (bus.wb_stb_o),
    .expired (tmo_expired)
  );

  // Command termination: normal end, bus error (wins over ack), or strobe timeout.
  always_comb begin
    fin    = 1'b0;
    fin_st = WB_ST_OK;
    case (state)
      ST_DONE: fin = 1'b1;
      ST_BUS: begin
        if (bus.wb_err_i) begin
          fin    = 1'b1;
          fin_st = WB_ST_ERR;
        end else if (!bus.wb_ack_i && tmo_expired) begin
          fin    = 1'b1;
          fin_st = WB_ST_TMO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rem           <= '0;
      beat_cnt      <= '0;
      bus.cmd_ready <= 1'b1;
      bus.wr_ready  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.status_o  <= WB_ST_OK;
      bus.beats_o   <= '0;
      bus.busy_o    <= 1'b0;
      bus.wb_adr_o  <= '0;
      bus.wb_dat_o  <= '0;
      bus.wb_we_o   <= 1'b0;
      bus.wb_sel_o  <= '0;
      bus.wb_stb_o  <= 1'b0;
      bus.wb_cyc_o  <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      if (bus.rd_valid && bus.rd_ready) bus.rd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            bus.busy_o    <= 1'b1;
            bus.wb_cyc_o  <= 1'b1;
            bus.wb_adr_o  <= bus.cmd_addr;
            bus.wb_we_o   <= bus.cmd_we;
            bus.wb_sel_o  <= bus.cmd_sel;
            rem           <= bus.cmd_len;
            beat_cnt      <= '0;
            if (bus.cmd_we) begin
              bus.wr_ready <= 1'b1;
              state        <= ST_WDATA;
            end else begin
              state        <= ST_REQ;
            end
          end
        end
        ST_WDATA: begin
          if (bus.wr_valid) begin
            bus.wr_ready <= 1'b0;
            bus.wb_dat_o <= bus.wr_data;
            bus.wb_stb_o <= 1'b1;
            state        <= ST_BUS;
          end
        end
        ST_REQ: begin
          // Only strobe once the read holding register is free (or freeing this cycle).
          if (!bus.rd_valid || bus.rd_ready) begin
            bus.wb_stb_o <= 1'b1;
            state        <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (!bus.wb_err_i && bus.wb_ack_i) begin
            bus.wb_stb_o <= 1'b0;
            beat_cnt     <= beat_cnt + (LEN_WIDTH+1)'(1);
            if (!bus.wb_we_o) begin
              bus.rd_data  <= bus.wb_dat_i;
              bus.rd_valid <= 1'b1;
            end
            if (rem == '0) begin
              state <= ST_DONE;
            end else begin
              rem          <= rem - LEN_WIDTH'(1);
              bus.wb_adr_o <= bus.wb_adr_o + ADDR_WIDTH'(SELECT_WIDTH);
              if (bus.wb_we_o) begin
                bus.wr_ready <= 1'b1;
                state        <= ST_WDATA;
              end else begin
                state        <= ST_REQ;
              end
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase

      if (fin) begin
        bus.wb_stb_o  <= 1'b0;
        bus.wb_cyc_o  <= 1'b0;
        bus.busy_o    <= 1'b0;
        bus.cmd_ready <= 1'b1;
        bus.done_o    <= 1'b1;
        bus.status_o  <= fin_st;
        bus.beats_o   <= beat_cnt;
        state         <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_ctl.sv
// Table-driven bench for wb_master_ctl against a registered-ack Wishbone RAM model.
// Hand sequences cover asynchronous reset mid-burst and recovery afterwards.
module tb_wb_master_ctl;
  localparam logic [31:0] NOERR = 32'h0000_0001;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bit          slv_on = 1'b1;
  logic [31:0] err_adr = NOERR;
  logic [31:0] mem     [1024];
  logic [31:0] exp_mem [1024];
  bit          slv_init;

  wb_master_ctl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(8)) bus ();

  wb_master_ctl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .LEN_WIDTH(8), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Wishbone RAM: one-cycle registered ack/err, ignores stb while ack/err is high.
  always @(posedge clk) begin
    if (!slv_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      slv_init <= 1'b1;
    end
    if (!rst_n) begin
      bus.wb_ack_i <= 1'b0;
      bus.wb_err_i <= 1'b0;
      bus.wb_dat_i <= '0;
    end else begin
      bus.wb_ack_i <= 1'b0;
      bus.wb_err_i <= 1'b0;
      if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i && !bus.wb_err_i && slv_on) begin
        if (bus.wb_adr_o == err_adr) begin
          bus.wb_err_i <= 1'b1;
        end else begin
          bus.wb_ack_i <= 1'b1;
          if (bus.wb_we_o) begin
            for (int b = 0; b < 4; b++)
              if (bus.wb_sel_o[b]) mem[bus.wb_adr_o[11:2]][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
          end else begin
            bus.wb_dat_i <= mem[bus.wb_adr_o[11:2]];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  sel;
    logic [31:0] base;
    logic [31:0] eadr;
    bit          ack_en;
    int          stall;
    bit          gap;
    logic [1:0]  st;
    int          beats;
    int          pulses;
    int          run;
  } vec_t;

  vec_t vt [10];

  task automatic run_cmd(input vec_t v, input string tag);
    logic [31:0] q_adr[$];
    logic [31:0] got[$];
    int          wi = 0, stall = v.stall, run = 0, maxrun = 0, viol = 0, mism = 0;
    bit          prev_stb = 1'b0, seen_done = 1'b0, accepted = 1'b0;
    logic [1:0]  st = 2'b11;
    logic [8:0]  bts = '1;
    logic        cyc_at_done = 1'b1, rdy_at_done = 1'b0;
    logic [31:0] a;

    @(posedge clk); #1;
    slv_on        = v.ack_en;
    err_adr       = v.eadr;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_we    = v.we;
    bus.cmd_sel   = v.sel;
    bus.cmd_valid = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = v.base;
    bus.rd_ready  = (stall == 0);
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready) accepted = 1'b1;
      if (bus.wb_stb_o && !prev_stb) begin
        q_adr.push_back(bus.wb_adr_o);
        if (bus.rd_valid) viol++;
      end
      if (bus.wb_stb_o) run++;
      else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      prev_stb = bus.wb_stb_o;
      if (bus.busy_o !== bus.wb_cyc_o) mism++;
      if (bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
      if (bus.wr_valid && bus.wr_ready) wi++;
      if (bus.done_o) begin
        seen_done   = 1'b1;
        st          = bus.status_o;
        bts         = bus.beats_o;
        cyc_at_done = bus.wb_cyc_o;
        rdy_at_done = bus.cmd_ready;
      end
      @(posedge clk); #1;
      if (accepted) bus.cmd_valid = 1'b0;
      if (stall > 0) begin
        stall--;
        bus.rd_ready = 1'b0;
      end else begin
        bus.rd_ready = 1'b1;
      end
      bus.wr_valid = v.we && !(v.gap && (c % 2 == 0));
      bus.wr_data  = v.base + 32'(wi);
    end
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    for (int d = 0; d < 30 && bus.rd_valid; d++) begin
      @(posedge clk); #1;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      if (bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
    end

    chk({tag, "_status"}, 64'(st), 64'(v.st));
    chk({tag, "_beats"}, 64'(bts), 64'(v.beats));
    chk({tag, "_stb_pulses"}, 64'(q_adr.size()), 64'(v.pulses));
    chk({tag, "_stb_run"}, 64'(maxrun), 64'(v.run));
    chk({tag, "_stb_while_rdvalid"}, 64'(viol), 64'd0);
    chk({tag, "_busy_vs_cyc"}, 64'(mism), 64'd0);
    chk({tag, "_cyc_at_done"}, 64'(cyc_at_done), 64'd0);
    chk({tag, "_cmd_ready_at_done"}, 64'(rdy_at_done), 64'd1);
    for (int i = 0; i < q_adr.size(); i++) begin
      a = v.addr + 32'(4 * i);
      chk($sformatf("%s_adr%0d", tag, i), 64'(q_adr[i]), 64'(a));
    end
    if (v.we) begin
      for (int i = 0; i < v.beats; i++) begin
        a = v.addr + 32'(4 * i);
        for (int b = 0; b < 4; b++)
          if (v.sel[b]) exp_mem[a[11:2]][8*b +: 8] = (v.base + 32'(i)) >> (8 * b);
      end
    end else begin
      chk({tag, "_rd_count"}, 64'(got.size()), 64'(v.beats));
      for (int i = 0; i < got.size() && i < v.beats; i++) begin
        a = v.addr + 32'(4 * i);
        chk($sformatf("%s_rd%0d", tag, i), 64'(got[i]), 64'(exp_mem[a[11:2]]));
      end
    end
  endtask

  initial begin
    int          nd;
    bit          hit;
    vec_t        rv;

    //        we addr          len sel   base           eadr     ack stall gap st  beats pulses run
    vt[0] = '{1'b1, 32'h100,     8'd0, 4'hF, 32'hDEADBEEF, NOERR,   1, 0,  0, 2'd0, 1, 1, 2};
    vt[1] = '{1'b0, 32'h100,     8'd0, 4'hF, 32'h0,        NOERR,   1, 0,  0, 2'd0, 1, 1, 2};
    vt[2] = '{1'b1, 32'h200,     8'd3, 4'hF, 32'h11110000, NOERR,   1, 0,  1, 2'd0, 4, 4, 2};
    vt[3] = '{1'b0, 32'h200,     8'd3, 4'hF, 32'h0,        NOERR,   1, 10, 0, 2'd0, 4, 4, 2};
    vt[4] = '{1'b1, 32'h300,     8'd3, 4'hF, 32'h22220000, 32'h304, 1, 0,  0, 2'd1, 1, 2, 2};
    vt[5] = '{1'b0, 32'h300,     8'd1, 4'hF, 32'h0,        NOERR,   1, 0,  0, 2'd0, 2, 2, 2};
    vt[6] = '{1'b0, 32'h000,     8'd3, 4'hF, 32'h0,        NOERR,   0, 0,  0, 2'd2, 0, 1, 16};
    vt[7] = '{1'b0, 32'hFFFFFFFC, 8'd1, 4'hF, 32'h0,       NOERR,   1, 0,  0, 2'd0, 2, 2, 2};
    vt[8] = '{1'b1, 32'h104,     8'd0, 4'h3, 32'h0000CAFE, NOERR,   1, 0,  0, 2'd0, 1, 1, 2};
    vt[9] = '{1'b0, 32'h104,     8'd0, 4'hF, 32'h0,        NOERR,   1, 0,  0, 2'd0, 1, 1, 2};

    for (int i = 0; i < 1024; i++) exp_mem[i] = pat(i);
    rst_n         = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = '0;
    bus.cmd_valid = 1'b0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_cmd(vt[i], $sformatf("v%0d", i));
    chk("rb_deadbeef", 64'(exp_mem[32'h100 >> 2]), 64'hDEADBEEF);

    // Reset in the middle of a stalled read burst.
    @(posedge clk); #1;
    slv_on        = 1'b1;
    err_adr       = NOERR;
    bus.rd_ready  = 1'b0;
    bus.cmd_addr  = 32'h200;
    bus.cmd_len   = 8'd3;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'hF;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      hit = bus.rd_valid;
    end
    chk("mid_rd_valid_pending", 64'(hit), 64'd1);
    chk("mid_cyc_before_rst", 64'(bus.wb_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    chk("mid_rst_stb", 64'(bus.wb_stb_o), 64'd0);
    chk("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done_o) nd++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done_o) nd++;
    end
    chk("mid_rst_no_done", 64'(nd), 64'd0);

    rv = vt[1];
    run_cmd(rv, "after_rst");
    rv = vt[7];
    run_cmd(rv, "after_rst_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
